comm_receiver: RTL and testbench
================================

// Module: comm_receiver
// PURPOSE
//  Serial command receiver; the far-end stage consuming the two-byte UART stream emitted by the command master.
//  Deserialises 8N1 UART frames and pairs bytes high-then-low into a 16-bit command.
//  Presents the command with a sticky cmd_rdy flag to the command-decode logic.
//  Self-contained: RX synchroniser, baud timing, byte FSM and pairing FSM all live here.
// PARAMETERS
//  BAUD_DIV     2604   clk cycles per bit period (50 MHz / 19200 baud); legal 8..65535
//  TIMEOUT_CYC  52080  max clk cycles in WAIT_LOW with no new start bit before high byte is dropped; legal >= 2*BAUD_DIV
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  RX           in   1   serial input, idle high, asynchronous to clk
//  clr_cmd_rdy  in   1   one-cycle pulse from consumer: command taken
//  cmd          out  16  last complete command {high byte, low byte}
//  cmd_rdy      out  1   sticky: cmd holds an unconsumed complete command
//  err          out  1   one-cycle pulse: framing error or inter-byte timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): cmd=16'h0000, cmd_rdy=0, err=0; RX synchroniser flops=1; both FSMs to idle; counters=0.
//  RX sync: 2 flops; all logic uses synced RX (rx_s).
//  Byte FSM states: IDLE, RECV.
//   IDLE: on rx_s 1->0 (prev synced sample 1, current 0) -> RECV.
//    Load baud_cnt=BAUD_DIV/2, bit_cnt=0.
//   RECV: baud_cnt decrements each clk; at 0 sample rx_s, reload BAUD_DIV-1, bit_cnt++.
//    Sample 0 is start bit; if 1 (glitch) -> IDLE, no byte, no err.
//    Samples 1..8 shift in LSB first; sample 9 is stop bit.
//    After stop sample -> IDLE same cycle.
//    stop=1: byte_vld pulse. stop=0: byte discarded, frm pulse.
//  Pairing FSM states: WAIT_HIGH, WAIT_LOW; 8-bit high_byte register.
//   WAIT_HIGH + byte_vld: high_byte<=byte, -> WAIT_LOW, to_cnt=0.
//   WAIT_LOW + byte_vld: cmd<={high_byte,byte}, cmd_rdy<=1, -> WAIT_HIGH.
//   WAIT_LOW: to_cnt++ each clk while byte FSM is IDLE; cleared while RECV.
//    to_cnt==TIMEOUT_CYC-1 -> WAIT_HIGH, high_byte dropped, err pulse.
//   frm in any pairing state -> WAIT_HIGH (resync to high byte), err pulse.
//   err is registered, exactly 1 cycle per event.
//  cmd_rdy:
//   Set only on low-byte completion.
//   Cleared by clr_cmd_rdy, or when a new high byte completes (byte_vld in WAIT_HIGH).
//   Set wins over simultaneous clr_cmd_rdy.
//  cmd changes only on low-byte completion; never on errors or timeouts.
//  Latency: cmd/cmd_rdy valid 1 clk after stop-bit sample of the low byte (~9.5 bit periods after its start edge).
//  Back-to-back frames with zero idle are accepted: the next falling edge is seen in IDLE after the stop sample.
//  Overrun: a new command overwrites cmd even if cmd_rdy still 1; no error flagged.
//  Reset mid-frame or mid-pair discards all partial state; first byte after reset is treated as high byte.
// TESTING (BAUD_DIV=16, TIMEOUT_CYC=64 in bench)
//  1. Send bytes 8'hA5 then 8'h3C, 1 idle bit between
//     -> cmd=16'hA53C, cmd_rdy=1 one clk after 2nd stop sample; err never 1.
//  2. After test 1, pulse clr_cmd_rdy -> cmd_rdy=0 next clk, cmd stays 16'hA53C.
//     Then send 8'h12,8'h34 back-to-back, zero idle -> cmd=16'h1234.
//  3. Send 8'hFF with stop bit driven 0 -> err pulse 1 clk, no cmd_rdy.
//     Then 8'h00,8'h01 -> cmd=16'h0001 (resync to high byte).
//  4. Send 8'h77, then idle 100 clks, then 8'h11,8'h22
//     -> err pulse at 64 clks into WAIT_LOW; then cmd=16'h1122, not 16'h7711.
//  5. 3-clk low glitch on RX -> no byte, no err; next 8'hDE,8'hAD -> cmd=16'hDEAD.
//  6. Assert rst_n=0 mid low byte of a pair
//     -> cmd=0, cmd_rdy=0, err=0 immediately; next pair 8'hBE,8'hEF -> cmd=16'hBEEF.
//     Also: clr_cmd_rdy in same clk as cmd completion -> cmd_rdy stays 1.

Source files
------------

// File: rtl/comm_receiver.sv
// comm_receiver: 8N1 UART receiver that pairs bytes high-then-low into a
// 16-bit command with a sticky ready flag and a one-cycle error pulse.
//
// Handshake: cmd_rdy rises one clk after the low byte's stop-bit sample and
// stays high until the consumer pulses clr_cmd_rdy for one cycle or a new
// high byte completes. If a completion and clr_cmd_rdy land on the same
// edge, the completion wins. cmd is stable while cmd_rdy is high, unless a
// newer command overwrites it.
module comm_receiver #(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 52080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic { B_IDLE, B_RECV } byte_state_t;
  typedef enum logic { P_WAIT_HIGH, P_WAIT_LOW } pair_state_t;

  // RX synchroniser plus the previous synced sample for edge detection.
  logic rx_m, rx_s, rx_p;

  // Byte FSM state and datapath.
  byte_state_t byte_state, byte_next;
  logic [15:0] baud_cnt, baud_next;
  logic [3:0]  bit_cnt, bit_next;
  logic [7:0]  shreg, sh_next;
  logic        byte_vld, frm;

  // Pairing FSM state and datapath.
  pair_state_t pair_state, pair_next;
  logic [7:0]    high_byte, high_next;
  logic [TW-1:0] to_cnt, to_next;
  logic [15:0]   cmd_next;
  logic          rdy_next, err_next;

  // Two-flop synchroniser; idle-high after reset so no false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  // Byte FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_state <= B_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else begin
      byte_state <= byte_state_t'(byte_next);
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shreg      <= sh_next;
    end
  end

  // Byte FSM: half-bit delay to the start-bit centre, then one sample per bit
  // period. Sample 0 rejects glitches, 1..8 shift data LSB first, 9 is stop.
  always_comb begin
    byte_next = byte_state;
    baud_next = baud_cnt;
    bit_next  = bit_cnt;
    sh_next   = shreg;
    byte_vld  = 1'b0;
    frm       = 1'b0;
    case (byte_state)
      B_IDLE: begin
        if (rx_p && !rx_s) begin
          byte_next = B_RECV;
          baud_next = 16'(BAUD_DIV / 2);
          bit_next  = 4'd0;
        end
      end
      B_RECV: begin
        if (baud_cnt == 16'd0) begin
          baud_next = 16'(BAUD_DIV - 1);
          bit_next  = bit_cnt + 4'd1;
          if (bit_cnt == 4'd0) begin
            if (rx_s) byte_next = B_IDLE;
          end else if (bit_cnt == 4'd9) begin
            byte_next = B_IDLE;
            if (rx_s) byte_vld = 1'b1;
            else      frm      = 1'b1;
          end else begin
            sh_next = {rx_s, shreg[7:1]};
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      default: byte_next = B_IDLE;
    endcase
  end

  // Pairing FSM registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_state <= P_WAIT_HIGH;
      high_byte  <= '0;
      to_cnt     <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      err        <= 1'b0;
    end else begin
      pair_state <= pair_state_t'(pair_next);
      high_byte  <= high_next;
      to_cnt     <= to_next;
      cmd        <= cmd_next;
      cmd_rdy    <= rdy_next;
      err        <= err_next;
    end
  end

  // Pairing FSM: first byte is the high byte, second completes the command.
  // The inter-byte timer only runs while the line is idle between frames.
  always_comb begin
    pair_next = pair_state;
    high_next = high_byte;
    to_next   = to_cnt;
    cmd_next  = cmd;
    rdy_next  = cmd_rdy;
    err_next  = 1'b0;
    if (clr_cmd_rdy) rdy_next = 1'b0;
    case (pair_state)
      P_WAIT_HIGH: begin
        to_next = '0;
        if (byte_vld) begin
          high_next = shreg;
          pair_next = P_WAIT_LOW;
          rdy_next  = 1'b0;
        end
      end
      P_WAIT_LOW: begin
        if (byte_vld) begin
          cmd_next  = {high_byte, shreg};
          rdy_next  = 1'b1;
          pair_next = P_WAIT_HIGH;
          to_next   = '0;
        end else if (byte_state == B_RECV) begin
          to_next = '0;
        end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          pair_next = P_WAIT_HIGH;
          err_next  = 1'b1;
          to_next   = '0;
        end else begin
          to_next = to_cnt + 1'b1;
        end
      end
      default: pair_next = P_WAIT_HIGH;
    endcase
    // A framing error resynchronises to the high byte from either state.
    if (frm) begin
      pair_next = P_WAIT_HIGH;
      err_next  = 1'b1;
      to_next   = '0;
    end
  end

endmodule

// File: tb/tb_comm_receiver.sv
// tb_comm_receiver: directed scenarios plus random frames against an
// event-level model of frame completion, pairing, timeout and ready flag.
module tb_comm_receiver;

  localparam int BAUD_DIV    = 16;
  localparam int TIMEOUT_CYC = 64;
  // Edges from the first edge that sees a start bit to the stop-bit decision:
  // two synchroniser stages, half-bit countdown (BAUD_DIV/2 .. 0), nine bits.
  localparam int DONE_LAT = 2 + BAUD_DIV / 2 + 1 + 9 * BAUD_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic cmd_rdy;
  logic err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  comm_receiver #(.BAUD_DIV(BAUD_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RX(rx),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .err(err)
  );

  // ---------------- model / scoreboard ----------------
  logic [15:0] exp_q[$];
  int cmd_evt[int];
  int err_at[int];
  int clr_at[int];
  int hclr_at[int];
  bit have_high;
  logic [7:0] high_val;
  int to_cyc;
  logic [15:0] exp_cmd;
  logic exp_rdy, prev_rdy;
  int last_rise = -1;
  int last_err = -1;
  int err_seen = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit run_chk = 1'b0;
  bit rand_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
  endtask

  function automatic void reset_model();
    exp_q.delete();
    cmd_evt.delete();
    err_at.delete();
    clr_at.delete();
    hclr_at.delete();
    have_high = 1'b0;
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
    prev_rdy = 1'b0;
  endfunction

  // A start edge reaching the receiver before the timeout edge keeps the
  // pending high byte; otherwise the timeout has already dropped it.
  function automatic void model_start(input int e0);
    if (have_high) begin
      if (e0 + 2 >= to_cyc) have_high = 1'b0;
      else err_at.delete(to_cyc);
    end
  endfunction

  function automatic void model_frame(input int e0, input logic [7:0] b, input logic stop);
    int c;
    c = e0 + DONE_LAT;
    model_start(e0);
    if (!stop) begin
      err_at[c] = 1;
      have_high = 1'b0;
    end else if (!have_high) begin
      have_high = 1'b1;
      high_val = b;
      hclr_at[c] = 1;
      to_cyc = c + TIMEOUT_CYC;
      err_at[to_cyc] = 1;
    end else begin
      exp_q.push_back({high_val, b});
      cmd_evt[c] = 1;
      have_high = 1'b0;
    end
  endfunction

  // Compare process: apply the model's events for this edge, then check.
  always @(negedge clk) begin
    #2;
    if (run_chk) begin
      if (clr_at.exists(cyc)) exp_rdy = 1'b0;
      if (hclr_at.exists(cyc)) exp_rdy = 1'b0;
      if (cmd_evt.exists(cyc)) begin
        exp_cmd = exp_q.pop_front();
        exp_rdy = 1'b1;
      end
      chk("cmd", cmd, exp_cmd);
      chk("cmd_rdy", cmd_rdy, exp_rdy);
      chk("err", err, err_at.exists(cyc));
      if (err === 1'b1) begin
        last_err = cyc;
        err_seen++;
      end
      if (cmd_rdy === 1'b1 && !prev_rdy) last_rise = cyc;
      prev_rdy = cmd_rdy;
    end
  end

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap, output int e0);
    e0 = cyc + 1;
    model_frame(e0, b, stop);
    rx = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    clr_at[cyc + 1] = 1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: run stopped at cycle %0d, got no finish, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0, e1, t, gap;
    logic [7:0] b;
    logic stop;
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_rdy", cmd_rdy, 1'b0);
    chk("reset_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk = 1'b1;
    repeat (20) @(negedge clk);

    // 1: two bytes with one idle bit between
    t = err_seen;
    send_frame(8'hA5, 1'b1, 16, e0);
    send_frame(8'h3C, 1'b1, 16, e1);
    chk("t1_cmd", cmd, 16'hA53C);
    chk("t1_rdy", cmd_rdy, 1'b1);
    chk("t1_latency", last_rise, e1 + 155);
    chk("t1_no_err", err_seen, t);

    // 2: consumer clear, then back-to-back frames with zero idle
    pulse_clr();
    chk("t2_clr", cmd_rdy, 1'b0);
    chk("t2_cmd_hold", cmd, 16'hA53C);
    send_frame(8'h12, 1'b1, 0, e0);
    send_frame(8'h34, 1'b1, 16, e1);
    chk("t2_cmd", cmd, 16'h1234);
    chk("t2_latency", last_rise, e1 + 155);

    // 3: framing error then resync to high byte
    pulse_clr();
    send_frame(8'hFF, 1'b0, 16, e0);
    chk("t3_err_time", last_err, e0 + 155);
    chk("t3_no_rdy", cmd_rdy, 1'b0);
    send_frame(8'h00, 1'b1, 16, e0);
    send_frame(8'h01, 1'b1, 16, e0);
    chk("t3_cmd", cmd, 16'h0001);

    // 4: inter-byte timeout drops the high byte
    send_frame(8'h77, 1'b1, 100, e0);
    chk("t4_timeout_time", last_err, e0 + 219);
    send_frame(8'h11, 1'b1, 16, e1);
    send_frame(8'h22, 1'b1, 16, e1);
    chk("t4_cmd", cmd, 16'h1122);

    // 5: short low glitch is not a frame
    t = err_seen;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_no_err", err_seen, t);
    send_frame(8'hDE, 1'b1, 16, e0);
    send_frame(8'hAD, 1'b1, 16, e0);
    chk("t5_cmd", cmd, 16'hDEAD);

    // 6: reset in the middle of the low byte
    send_frame(8'h55, 1'b1, 16, e0);
    model_start(cyc + 1);
    rx = 1'b0;
    repeat (BAUD_DIV * 4) @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("t6_rst_cmd", cmd, 16'h0000);
    chk("t6_rst_rdy", cmd_rdy, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'hBE, 1'b1, 16, e0);
    fork
      send_frame(8'hEF, 1'b1, 16, e1);
      begin
        repeat (DONE_LAT) @(negedge clk);
        pulse_clr();
      end
    join
    chk("t6_cmd", cmd, 16'hBEEF);
    chk("t6_set_beats_clr", cmd_rdy, 1'b1);

    // random frames, gaps, bad stop bits and consumer clears
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          b = 8'($urandom_range(0, 255));
          stop = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, 3) == 0) gap = $urandom_range(70, 120);
          else gap = $urandom_range(0, 40);
          if (!stop && gap < 16) gap = 16;
          send_frame(b, stop, gap, e0);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          repeat ($urandom_range(30, 250)) @(negedge clk);
          if (rand_on) pulse_clr();
        end
      end
    join
    repeat (300) @(negedge clk);
    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
